// File: rtl/mem_wb_stage.sv
// Memory-access to write-back pipeline register with a saturating retire counter.
// Define MEM_WB_FWD_EN to drive the Fwd_* outputs from the write-back path; otherwise they read 0.
module mem_wb_stage #(
  parameter int DATA_LEN     = 32,
  parameter int REG_ADDR_LEN = 4,
  parameter int CNT_LEN      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    freeze,
  input  logic                    flush,
  input  logic                    in_valid,
  input  logic                    WB_EN_in,
  input  logic                    MEM_R_EN_in,
  input  logic [DATA_LEN-1:0]     ALU_Res_in,
  input  logic [DATA_LEN-1:0]     MEM_OUT_in,
  input  logic [REG_ADDR_LEN-1:0] Dest_in,
  output logic                    WB_EN,
  output logic [REG_ADDR_LEN-1:0] WB_Dest,
  output logic [DATA_LEN-1:0]     WB_Value,
  output logic                    out_valid,
  output logic [CNT_LEN-1:0]      retire_cnt,
  output logic                    Fwd_EN,
  output logic [REG_ADDR_LEN-1:0] Fwd_Dest,
  output logic [DATA_LEN-1:0]     Fwd_Value
);

  logic                    valid_p0;
  logic                    wb_en_p0;
  logic                    mem_r_en_p0;
  logic [DATA_LEN-1:0]     alu_res_p0;
  logic [DATA_LEN-1:0]     mem_out_p0;
  logic [REG_ADDR_LEN-1:0] dest_p0;
  logic [CNT_LEN-1:0]      cnt_p0;

  // Counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_LEN-1:0] sat_inc(input logic [CNT_LEN-1:0] v);
    if (&v)
      return v;
    return v + {{(CNT_LEN-1){1'b0}}, 1'b1};
  endfunction

  // Stage p0: capture from the memory-access stage
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_p0    <= 1'b0;
      wb_en_p0    <= 1'b0;
      mem_r_en_p0 <= 1'b0;
      alu_res_p0  <= '0;
      mem_out_p0  <= '0;
      dest_p0     <= '0;
      cnt_p0      <= '0;
    end else if (flush) begin
      valid_p0 <= 1'b0;
      wb_en_p0 <= 1'b0;
    end else if (!freeze) begin
      valid_p0    <= in_valid;
      wb_en_p0    <= WB_EN_in;
      mem_r_en_p0 <= MEM_R_EN_in;
      alu_res_p0  <= ALU_Res_in;
      mem_out_p0  <= MEM_OUT_in;
      dest_p0     <= Dest_in;
      if (in_valid && WB_EN_in)
        cnt_p0 <= sat_inc(cnt_p0);
    end
  end

  // Write-back outputs, decoded from p0 registers only
  assign WB_EN      = valid_p0 & wb_en_p0;
  assign WB_Dest    = dest_p0;
  assign WB_Value   = mem_r_en_p0 ? mem_out_p0 : alu_res_p0;
  assign out_valid  = valid_p0;
  assign retire_cnt = cnt_p0;

`ifdef MEM_WB_FWD_EN
  assign Fwd_EN    = WB_EN;
  assign Fwd_Dest  = WB_Dest;
  assign Fwd_Value = WB_Value;
`else
  assign Fwd_EN    = 1'b0;
  assign Fwd_Dest  = '0;
  assign Fwd_Value = '0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed scenarios plus randomized traffic against a transaction-level model.
// A second instance with CNT_LEN=4 exercises counter saturation.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst, freeze, flush, in_valid, wb_en_in, mem_r_en_in;
  logic [31:0] alu_res_in, mem_out_in;
  logic [3:0]  dest_in;

  logic        wb_en, out_valid, fwd_en;
  logic [3:0]  wb_dest, fwd_dest;
  logic [31:0] wb_value, fwd_value;
  logic [15:0] retire_cnt;

  logic        wb_en4, out_valid4, fwd_en4;
  logic [3:0]  wb_dest4, fwd_dest4;
  logic [31:0] wb_value4, fwd_value4;
  logic [3:0]  retire_cnt4;

  int vectors = 0;
  int errors  = 0;

  // Transaction-level model: what the stage should be presenting right now.
  logic        m_valid, m_wben, m_known;
  logic [3:0]  m_dest;
  logic [31:0] m_value;
  int          m_cnt;

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .in_valid(in_valid),
    .WB_EN_in(wb_en_in), .MEM_R_EN_in(mem_r_en_in), .ALU_Res_in(alu_res_in),
    .MEM_OUT_in(mem_out_in), .Dest_in(dest_in), .WB_EN(wb_en), .WB_Dest(wb_dest),
    .WB_Value(wb_value), .out_valid(out_valid), .retire_cnt(retire_cnt),
    .Fwd_EN(fwd_en), .Fwd_Dest(fwd_dest), .Fwd_Value(fwd_value)
  );

  mem_wb_stage #(.CNT_LEN(4)) dut4 (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .in_valid(in_valid),
    .WB_EN_in(wb_en_in), .MEM_R_EN_in(mem_r_en_in), .ALU_Res_in(alu_res_in),
    .MEM_OUT_in(mem_out_in), .Dest_in(dest_in), .WB_EN(wb_en4), .WB_Dest(wb_dest4),
    .WB_Value(wb_value4), .out_valid(out_valid4), .retire_cnt(retire_cnt4),
    .Fwd_EN(fwd_en4), .Fwd_Dest(fwd_dest4), .Fwd_Value(fwd_value4)
  );

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_wben = 0; m_dest = 0; m_value = 0; m_cnt = 0; m_known = 1;
    end else if (flush) begin
      m_valid = 0; m_wben = 0; m_known = 0;
    end else if (!freeze) begin
      m_valid = in_valid;
      m_wben  = in_valid && wb_en_in;
      m_dest  = dest_in;
      m_value = mem_r_en_in ? mem_out_in : alu_res_in;
      m_known = 1;
      if (in_valid && wb_en_in) m_cnt++;
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic rd,
                       input logic [31:0] alu, input logic [31:0] mem, input logic [3:0] d);
    in_valid = v; wb_en_in = we; mem_r_en_in = rd;
    alu_res_in = alu; mem_out_in = mem; dest_in = d;
  endtask

  task automatic test_reset();
    rst = 1; freeze = 0; flush = 0;
    drive(1'b1, 1'b1, 1'b0, 32'h1234_5678, 32'h9abc_def0, 4'd7);
    tick(); tick();
    rst = 0;
    vectors++;
    if ({wb_en, out_valid, wb_dest, wb_value, retire_cnt} !== 54'd0) begin
      errors++;
      $display("FAIL reset_state got %h want 0", {wb_en, out_valid, wb_dest, wb_value, retire_cnt});
    end
    vectors++;
    if ({fwd_en, fwd_dest, fwd_value, retire_cnt4} !== 41'd0) begin
      errors++;
      $display("FAIL reset_fwd got %h want 0", {fwd_en, fwd_dest, fwd_value, retire_cnt4});
    end
  endtask

  task automatic test_basic_write();
    logic [36:0] exp_fwd;
    drive(1'b1, 1'b1, 1'b0, 32'h0000_0400, 32'h5555_aaaa, 4'd3);
    tick();
    vectors++;
    if ({wb_en, out_valid, wb_dest, wb_value, retire_cnt} !== {1'b1, 1'b1, 4'd3, 32'h400, 16'd1}) begin
      errors++;
      $display("FAIL basic_write got %h want %h", {wb_en, out_valid, wb_dest, wb_value, retire_cnt},
               {1'b1, 1'b1, 4'd3, 32'h400, 16'd1});
    end
`ifdef MEM_WB_FWD_EN
    exp_fwd = {1'b1, 4'd3, 32'h400};
`else
    exp_fwd = '0;
`endif
    vectors++;
    if ({fwd_en, fwd_dest, fwd_value} !== exp_fwd) begin
      errors++;
      $display("FAIL fwd_ports got %h want %h", {fwd_en, fwd_dest, fwd_value}, exp_fwd);
    end
  endtask

  task automatic test_load();
    drive(1'b1, 1'b1, 1'b1, 32'h0000_0404, 32'hDEAD_BEEF, 4'd5);
    tick();
    vectors++;
    if ({wb_en, wb_dest, wb_value, retire_cnt} !== {1'b1, 4'd5, 32'hDEAD_BEEF, 16'd2}) begin
      errors++;
      $display("FAIL load_value got %h want %h", {wb_en, wb_dest, wb_value, retire_cnt},
               {1'b1, 4'd5, 32'hDEAD_BEEF, 16'd2});
    end
  endtask

  task automatic test_freeze_flush();
    freeze = 1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, $urandom_range(0, 1), $urandom, $urandom, 4'($urandom));
      tick();
      vectors++;
      if ({wb_en, out_valid, wb_dest, wb_value, retire_cnt} !== {1'b1, 1'b1, 4'd5, 32'hDEAD_BEEF, 16'd2}) begin
        errors++;
        $display("FAIL freeze_hold[%0d] got %h want %h", i, {wb_en, out_valid, wb_dest, wb_value, retire_cnt},
                 {1'b1, 1'b1, 4'd5, 32'hDEAD_BEEF, 16'd2});
      end
    end
    flush = 1;
    tick();
    vectors++;
    if ({wb_en, out_valid, retire_cnt} !== {1'b0, 1'b0, 16'd2}) begin
      errors++;
      $display("FAIL flush_over_freeze got %h want %h", {wb_en, out_valid, retire_cnt}, {1'b0, 1'b0, 16'd2});
    end
    flush = 0; freeze = 0;
  endtask

  task automatic test_bubble();
    drive(1'b0, 1'b1, 1'b0, 32'h0000_0777, 32'h0, 4'd9);
    tick();
    vectors++;
    if ({wb_en, out_valid, wb_dest, wb_value, retire_cnt} !== {1'b0, 1'b0, 4'd9, 32'h777, 16'd2}) begin
      errors++;
      $display("FAIL bubble got %h want %h", {wb_en, out_valid, wb_dest, wb_value, retire_cnt},
               {1'b0, 1'b0, 4'd9, 32'h777, 16'd2});
    end
  endtask

  task automatic test_reset_midstream();
    drive(1'b1, 1'b1, 1'b0, 32'h0000_0abc, 32'h0, 4'd12);
    tick();
    vectors++;
    if ({wb_en, retire_cnt} !== {1'b1, 16'd3}) begin
      errors++;
      $display("FAIL pre_reset_write got %h want %h", {wb_en, retire_cnt}, {1'b1, 16'd3});
    end
    rst = 1; flush = 1; freeze = 1;
    tick();
    rst = 0; flush = 0; freeze = 0;
    vectors++;
    if ({wb_en, out_valid, wb_dest, wb_value, retire_cnt, fwd_en, fwd_dest, fwd_value} !== 91'd0) begin
      errors++;
      $display("FAIL reset_midstream got %h want 0",
               {wb_en, out_valid, wb_dest, wb_value, retire_cnt, fwd_en, fwd_dest, fwd_value});
    end
  endtask

  task automatic test_saturate();
    for (int i = 1; i <= 20; i++) begin
      drive(1'b1, 1'b1, 1'b0, $urandom, $urandom, 4'($urandom));
      tick();
      vectors++;
      if (retire_cnt4 !== 4'((i > 15) ? 15 : i) || retire_cnt !== 16'(i)) begin
        errors++;
        $display("FAIL saturate[%0d] got cnt4=%h cnt16=%h want cnt4=%h cnt16=%h", i, retire_cnt4, retire_cnt,
                 4'((i > 15) ? 15 : i), 16'(i));
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] e16;
    logic [3:0]  e4;
    for (int i = 0; i < 400; i++) begin
      rst    = ($urandom_range(0, 63) == 0);
      flush  = ($urandom_range(0, 7) == 0);
      freeze = ($urandom_range(0, 3) == 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1),
            $urandom, $urandom, 4'($urandom));
      tick();
      e16 = (m_cnt > 65535) ? 16'hFFFF : 16'(m_cnt);
      e4  = (m_cnt > 15) ? 4'hF : 4'(m_cnt);
      vectors++;
      if ({wb_en, out_valid, retire_cnt, wb_en4, retire_cnt4} !== {m_wben, m_valid, e16, m_wben, e4}) begin
        errors++;
        $display("FAIL random_ctrl[%0d] got %h want %h", i, {wb_en, out_valid, retire_cnt, wb_en4, retire_cnt4},
                 {m_wben, m_valid, e16, m_wben, e4});
      end
      if (m_known) begin
        vectors++;
        if ({wb_dest, wb_value} !== {m_dest, m_value}) begin
          errors++;
          $display("FAIL random_data[%0d] got %h want %h", i, {wb_dest, wb_value}, {m_dest, m_value});
        end
      end
`ifdef MEM_WB_FWD_EN
      vectors++;
      if (fwd_en !== m_wben) begin
        errors++;
        $display("FAIL random_fwd[%0d] got %b want %b", i, fwd_en, m_wben);
      end
`else
      vectors++;
      if ({fwd_en, fwd_dest, fwd_value} !== 37'd0) begin
        errors++;
        $display("FAIL random_fwd[%0d] got %h want 0", i, {fwd_en, fwd_dest, fwd_value});
      end
`endif
    end
    rst = 0; flush = 0; freeze = 0;
  endtask

  initial begin
    rst = 1; freeze = 0; flush = 0;
    m_valid = 0; m_wben = 0; m_dest = 0; m_value = 0; m_cnt = 0; m_known = 0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
    test_reset();
    test_basic_write();
    test_load();
    test_freeze_flush();
    test_bubble();
    test_reset_midstream();
    test_saturate();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have parameter DATA_LEN, default 32, the data width of every value field.
REQ-002 SHALL have parameter REG_ADDR_LEN, default 4, the register-file index width.
REQ-003 SHALL have parameter CNT_LEN, default 16, the width of the retire counter.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset, synchronous, active-high.
REQ-006 SHALL have port freeze, input, 1: hold all state.
REQ-007 SHALL have port flush, input, 1: invalidate the captured instruction.
REQ-008 SHALL have port in_valid, input, 1: the memory-access stage presents a real instruction.
REQ-009 SHALL have port WB_EN_in, input, 1: the instruction writes the register file.
REQ-010 SHALL have port MEM_R_EN_in, input, 1: the instruction is a load.
REQ-011 SHALL have port ALU_Res_in, input, DATA_LEN: ALU result/address.
REQ-012 SHALL have port MEM_OUT_in, input, DATA_LEN: load data, valid when MEM_R_EN_in=1.
REQ-013 SHALL have port Dest_in, input, REG_ADDR_LEN: destination register.
REQ-014 SHALL have port WB_EN, output, 1: register-file write enable.
REQ-015 SHALL have port WB_Dest, output, REG_ADDR_LEN: write index.
REQ-016 SHALL have port WB_Value, output, DATA_LEN: write data.
REQ-017 SHALL have port out_valid, output, 1: the stage holds a valid instruction.
REQ-018 SHALL have port retire_cnt, output, CNT_LEN: count of retired writing instructions.
REQ-019 SHALL have ports Fwd_EN (1), Fwd_Dest (REG_ADDR_LEN), Fwd_Value (DATA_LEN), all outputs, for forwarding to execute.

Function
REQ-020 SHALL register in_valid, WB_EN_in, MEM_R_EN_in, ALU_Res_in, MEM_OUT_in and Dest_in on each rising edge when rst=0, flush=0 and freeze=0.
REQ-021 SHALL give a latency of exactly one cycle from the inputs to WB_EN/WB_Dest/WB_Value.
REQ-022 SHALL, when freeze=1 and flush=0, hold every register, including retire_cnt, unchanged.
REQ-023 SHALL, when flush=1, clear the valid bit and the write-enable bit at the edge; data fields are don't-care; flush overrides freeze.
REQ-024 SHALL drive WB_EN = valid AND registered WB_EN_in, combinationally from registers only.
REQ-025 SHALL drive WB_Value = registered MEM_OUT_in when registered MEM_R_EN_in=1, else registered ALU_Res_in.
REQ-026 SHALL drive WB_Dest = registered Dest_in, and out_valid = valid bit.
REQ-027 SHALL increment retire_cnt by 1 at each edge where a capture per REQ-020 occurs with in_valid=1 and WB_EN_in=1.
REQ-028 SHALL saturate retire_cnt at all-ones; it SHALL never wrap.
REQ-029 SHALL treat in_valid=0 captures as bubbles: WB_EN=0 the following cycle regardless of WB_EN_in.
REQ-030 SHALL not change retire_cnt on flush or freeze cycles.

Reset
REQ-031 SHALL, on a rising edge with rst=1, clear every register: valid, WB_EN, WB_Dest, WB_Value, retire_cnt and Fwd_* all read 0 the next cycle.
REQ-032 SHALL give rst priority over flush and freeze; a reset mid-stream discards the held instruction.

Configuration
REQ-033 SHALL, with macro MEM_WB_FWD_EN defined, drive Fwd_EN=WB_EN, Fwd_Dest=WB_Dest, Fwd_Value=WB_Value.
REQ-034 SHALL, with MEM_WB_FWD_EN undefined, tie Fwd_EN, Fwd_Dest and Fwd_Value to 0; the ports still exist.

Verification
REQ-035 SHALL check: reset, then in_valid=1, WB_EN_in=1, MEM_R_EN_in=0, ALU_Res_in=32'h0000_0400, Dest_in=3 -> next cycle WB_EN=1, WB_Dest=3, WB_Value=32'h400, retire_cnt=1.
REQ-036 SHALL check: a load with MEM_R_EN_in=1, MEM_OUT_in=32'hDEAD_BEEF, ALU_Res_in=32'h404 -> WB_Value=32'hDEAD_BEEF.
REQ-037 SHALL check: freeze=1 for 3 cycles while inputs change -> outputs and retire_cnt constant; flush=1 with freeze=1 -> WB_EN=0, out_valid=0 next cycle.
REQ-038 SHALL check: CNT_LEN=4, 20 back-to-back writing instructions -> retire_cnt stops at 4'hF.
REQ-039 SHALL check: rst=1 asserted while WB_EN=1 -> all outputs 0 the next cycle; in_valid=0 with WB_EN_in=1 -> WB_EN=0.
REQ-040 SHALL check: the REQ-035 stimulus with MEM_WB_FWD_EN defined -> Fwd_EN=1, Fwd_Dest=3, Fwd_Value=32'h400; with MEM_WB_FWD_EN undefined -> Fwd_* = 0.
